xor_parity_serializer: RTL and testbench

//  Parallel-to-serial framer. Accepts DATA_W-bit words over a valid/ready handshake.

---
 rtl/xor_parity_serializer_pkg.sv | 15 +
 rtl/xor_parity_serializer_if.sv | 41 ++++
 rtl/xor_parity_serializer_bit_acc.sv | 29 ++
 rtl/xor_parity_serializer.sv | 135 +++++++++++++
 tb/tb_xor_parity_serializer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_parity_serializer_pkg.sv
// Shared types and helpers for the serial parity transmitter.
// State encodings are fixed so traces decode the same everywhere.
package xor_parity_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   function automatic int cnt_w(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/xor_parity_serializer_if.sv
// Word-in / bit-out handshake bundle of the parity serializer.
// slave is the serializer's view, master the surrounding logic.
interface xor_parity_serializer_if #(
   parameter int DATA_W = 8
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              ser_valid;
   logic              ser_ready;
   logic              ser_out;
   logic              ser_is_par;
   logic              frame_start;
   logic              busy;

   modport master (
      output in_valid,
      output in_data,
      output ser_ready,
      input  in_ready,
      input  ser_valid,
      input  ser_out,
      input  ser_is_par,
      input  frame_start,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  ser_ready,
      output in_ready,
      output ser_valid,
      output ser_out,
      output ser_is_par,
      output frame_start,
      output busy
   );

endinterface

// File: rtl/xor_parity_serializer_bit_acc.sv
// One-bit running parity register; its next value comes from
// a 2-input XOR gate cell so it maps straight onto that cell.
module xor_bit_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic load,
   input  logic load_val,
   input  logic en,
   input  logic din,
   output logic q,
   output logic nxt
);

   xor u_xor (nxt, q, din);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else if (clr) begin
         q <= 1'b0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/xor_parity_serializer.sv
// Parallel-to-serial framer: LSB-first data bits, then one
// parity bit, with back-to-back frames on the parity cycle.
module xor_parity_serializer
   import xor_parity_serializer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   xor_parity_serializer_if.slave bus
);

   localparam int CW = cnt_w(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   state_t state, state_n;

   // bit 0 goes straight to ser_out, so only the upper bits queue
   logic [DATA_W-2:0] shift_q, shift_n;
   logic [CW-1:0]     cnt_q, cnt_n;

   logic out_q, out_n;
   logic vld_q, vld_n;
   logic par_q, par_n;
   logic fst_q, fst_n;

   logic acc_q, acc_nxt;
   logic acc_clr, acc_load, acc_en;
   logic accept, emit;

   assign bus.in_ready =
      (state == ST_IDLE) |
      ((state == ST_PARITY) & bus.ser_ready);

   assign accept = bus.in_valid & bus.in_ready;
   assign emit   = vld_q & bus.ser_ready;

   assign bus.ser_valid   = vld_q;
   assign bus.ser_out     = out_q;
   assign bus.ser_is_par  = par_q;
   assign bus.frame_start = fst_q;
   assign bus.busy        = (state != ST_IDLE);

   xor_bit_acc u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .load     (acc_load),
      .load_val (PARITY_ODD),
      .en       (acc_en),
      .din      (out_q),
      .q        (acc_q),
      .nxt      (acc_nxt)
   );

   always_comb begin
      state_n  = state;
      shift_n  = shift_q;
      cnt_n    = cnt_q;
      out_n    = out_q;
      vld_n    = vld_q;
      par_n    = par_q;
      fst_n    = fst_q;
      acc_clr  = 1'b0;
      acc_load = 1'b0;
      acc_en   = 1'b0;
      // accept only happens in IDLE or on the parity bit's emit
      if (accept) begin
         state_n  = ST_DATA;
         shift_n  = bus.in_data[DATA_W-1:1];
         out_n    = bus.in_data[0];
         cnt_n    = '0;
         vld_n    = 1'b1;
         par_n    = 1'b0;
         fst_n    = 1'b1;
         acc_load = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
            end
            ST_DATA: begin
               if (emit) begin
                  acc_en = 1'b1;
                  fst_n  = 1'b0;
                  if (cnt_q == LAST) begin
                     out_n   = acc_nxt;
                     par_n   = 1'b1;
                     state_n = ST_PARITY;
                  end else begin
                     out_n   = shift_q[0];
                     shift_n = shift_q >> 1;
                     cnt_n   = cnt_q + CW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (emit) begin
                  vld_n   = 1'b0;
                  par_n   = 1'b0;
                  acc_clr = 1'b1;
                  state_n = ST_IDLE;
               end
            end
            default: begin
               state_n = ST_IDLE;
               vld_n   = 1'b0;
               par_n   = 1'b0;
               fst_n   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         vld_q   <= 1'b0;
         par_q   <= 1'b0;
         fst_q   <= 1'b0;
      end else begin
         state   <= state_n;
         shift_q <= shift_n;
         cnt_q   <= cnt_n;
         out_q   <= out_n;
         vld_q   <= vld_n;
         par_q   <= par_n;
         fst_q   <= fst_n;
      end
   end

endmodule

// File: tb/tb_xor_parity_serializer.sv
// Drives an even- and an odd-parity serializer with identical
// stimulus; table vectors, corner sequences, then random traffic.
module tb_xor_parity_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       ser_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   bit [2:0] q [2][$];

   typedef struct {
      logic [7:0] data;
      logic       par_even;
      logic       par_odd;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   xor_parity_serializer_if #(.DATA_W(8)) e_if ();
   xor_parity_serializer_if #(.DATA_W(8)) o_if ();

   assign e_if.in_valid  = in_valid;
   assign e_if.in_data   = in_data;
   assign e_if.ser_ready = ser_ready;
   assign o_if.in_valid  = in_valid;
   assign o_if.in_data   = in_data;
   assign o_if.ser_ready = ser_ready;

   xor_parity_serializer #(
      .DATA_W(8), .PARITY_ODD(1'b0)
   ) dut_e (
      .clk(clk), .rst_n(rst_n), .bus(e_if)
   );

   xor_parity_serializer #(
      .DATA_W(8), .PARITY_ODD(1'b1)
   ) dut_o (
      .clk(clk), .rst_n(rst_n), .bus(o_if)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_e_vld"}, e_if.ser_valid, 0);
      chk({nm, "_e_out"}, e_if.ser_out, 0);
      chk({nm, "_e_par"}, e_if.ser_is_par, 0);
      chk({nm, "_e_fs"}, e_if.frame_start, 0);
      chk({nm, "_e_busy"}, e_if.busy, 0);
      chk({nm, "_e_rdy"}, e_if.in_ready, 1);
      chk({nm, "_o_vld"}, o_if.ser_valid, 0);
      chk({nm, "_o_out"}, o_if.ser_out, 0);
      chk({nm, "_o_par"}, o_if.ser_is_par, 0);
      chk({nm, "_o_fs"}, o_if.frame_start, 0);
      chk({nm, "_o_busy"}, o_if.busy, 0);
      chk({nm, "_o_rdy"}, o_if.in_ready, 1);
   endtask

   task automatic chk_done(input string nm);
      chk({nm, "_e_vld"}, e_if.ser_valid, 0);
      chk({nm, "_e_busy"}, e_if.busy, 0);
      chk({nm, "_o_vld"}, o_if.ser_valid, 0);
      chk({nm, "_o_busy"}, o_if.busy, 0);
   endtask

   task automatic chk_bit(input string nm, input int i,
                          input logic [7:0] d,
                          input logic pe, input logic po,
                          input logic rdy);
      logic be, bo;
      be = (i < 8) ? d[i] : pe;
      bo = (i < 8) ? d[i] : po;
      chk({nm, "_e_vld"}, e_if.ser_valid, 1);
      chk({nm, "_e_out"}, e_if.ser_out, be);
      chk({nm, "_e_par"}, e_if.ser_is_par, i == 8);
      chk({nm, "_e_fs"}, e_if.frame_start, i == 0);
      chk({nm, "_e_busy"}, e_if.busy, 1);
      chk({nm, "_e_rdy"}, e_if.in_ready, rdy);
      chk({nm, "_o_vld"}, o_if.ser_valid, 1);
      chk({nm, "_o_out"}, o_if.ser_out, bo);
      chk({nm, "_o_par"}, o_if.ser_is_par, i == 8);
      chk({nm, "_o_fs"}, o_if.frame_start, i == 0);
      chk({nm, "_o_busy"}, o_if.busy, 1);
      chk({nm, "_o_rdy"}, o_if.in_ready, rdy);
   endtask

   task automatic start_word(input logic [7:0] d);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      chk("start_e_rdy", e_if.in_ready, 1);
      chk("start_o_rdy", o_if.in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_frame(input logic [7:0] d,
                               input logic pe,
                               input logic po,
                               input int stall_at,
                               input int stall_len);
      int hold;
      for (int i = 0; i < 9; i++) begin
         hold = (i == stall_at) ? stall_len : 0;
         for (int c = 0; c <= hold; c++) begin
            ser_ready = (c == hold);
            @(negedge clk);
            chk_bit($sformatf("f%02h_b%0d_c%0d", d, i, c),
                    i, d, pe, po, (i == 8) && (c == hold));
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic rnd_step(input int k, input bit odd,
                           input logic iv, input logic ir,
                           input logic sv, input logic sr,
                           input logic so, input logic sp,
                           input logic fs,
                           input logic [7:0] d);
      bit [2:0] it;
      int ones;
      chk($sformatf("rnd%0d_vld", k), sv, q[k].size() != 0);
      if (sv && sr && q[k].size() != 0) begin
         it = q[k].pop_front();
         chk($sformatf("rnd%0d_out", k), so, it[0]);
         chk($sformatf("rnd%0d_par", k), sp, it[1]);
         chk($sformatf("rnd%0d_fs", k), fs, it[2]);
      end
      if (iv && ir) begin
         ones = $countones(d);
         for (int i = 0; i < 8; i++)
            q[k].push_back({i == 0, 1'b0, d[i]});
         q[k].push_back({2'b01, 1'((ones + int'(odd)) % 2)});
      end
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1};
      vecs[1] = '{8'h07, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 1'b0, 1'b1};
      vecs[5] = '{8'h01, 1'b1, 1'b0};
      vecs[6] = '{8'h3C, 1'b0, 1'b1};
      vecs[7] = '{8'h5A, 1'b0, 1'b1};

      ser_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[v]) begin
         start_word(vecs[v].data);
         expect_frame(vecs[v].data, vecs[v].par_even,
                      vecs[v].par_odd, -1, 0);
         @(negedge clk);
         chk_done($sformatf("tbl%0d_end", v));
         @(posedge clk);
         #1;
      end

      start_word(8'h3C);
      expect_frame(8'h3C, 1'b0, 1'b1, 4, 3);
      @(negedge clk);
      chk_done("stall_end");
      @(posedge clk);
      #1;

      in_data  = 8'hFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_data = 8'h01;
      expect_frame(8'hFF, 1'b0, 1'b1, -1, 0);
      in_valid = 1'b0;
      expect_frame(8'h01, 1'b1, 1'b0, -1, 0);
      @(negedge clk);
      chk_done("b2b_end");
      @(posedge clk);
      #1;

      start_word(8'hA5);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_e_vld", e_if.ser_valid, 1);
      chk("mid_e_busy", e_if.busy, 1);
      chk("mid_o_vld", o_if.ser_valid, 1);
      #1 rst_n = 1'b0;
      #1 chk_idle("rst_mid");
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_word(8'h80);
      expect_frame(8'h80, 1'b1, 1'b0, -1, 0);
      @(negedge clk);
      chk_done("after_rst_end");

      #1 rst_n = 1'b0;
      #1 chk_idle("rst2");
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_data  = 8'h5A;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      expect_frame(8'h5A, 1'b0, 1'b1, 3, 2);
      in_valid = 1'b0;
      expect_frame(8'h5A, 1'b0, 1'b1, -1, 0);
      @(negedge clk);
      chk_done("hold_end");
      @(posedge clk);
      #1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         ser_ready = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         if (cyc >= 2950) begin
            in_valid  = 1'b0;
            ser_ready = 1'b1;
         end
         @(negedge clk);
         rnd_step(0, 1'b0, in_valid, e_if.in_ready,
                  e_if.ser_valid, ser_ready, e_if.ser_out,
                  e_if.ser_is_par, e_if.frame_start, in_data);
         rnd_step(1, 1'b1, in_valid, o_if.in_ready,
                  o_if.ser_valid, ser_ready, o_if.ser_out,
                  o_if.ser_is_par, o_if.frame_start, in_data);
         @(posedge clk);
         #1;
      end
      chk("rnd0_drained", q[0].size(), 0);
      chk("rnd1_drained", q[1].size(), 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
